// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_pkg.sv
// Shared types and sizing helpers for the break-before-make synchronous channel mux.
package gf180mcu_fd_sc_mcu9t5v0__muxn_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    STEADY = 2'd0,
    BREAK  = 2'd1,
    MAKE   = 2'd2
  } state_e;

  // Select width never collapses to zero bits, even for a two-channel mux.
  function automatic int sel_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_hcnt.sv
// Break-interval down-counter: loads a start value, counts down to zero while enabled.
module gf180mcu_fd_sc_mcu9t5v0__muxn_hcnt
  import gf180mcu_fd_sc_mcu9t5v0__muxn_pkg::*;
(
  input  logic             CLK,
  input  logic             RN,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// Registered N-channel mux with break-before-make select switching.
// Define GF180MCU_FD_SC_MCU9T5V0__MUXN_PARK_EN to drive Z to zero during the break.
module gf180mcu_fd_sc_mcu9t5v0__muxn_sync
  import gf180mcu_fd_sc_mcu9t5v0__muxn_pkg::*;
#(
  parameter  int WIDTH     = 1,
  parameter  int NCH       = 4,
  parameter  int BREAK_CYC = 1,
  parameter  int RST_SEL   = 0,
  localparam int SEL_W     = sel_width(NCH)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NCH*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]     S,
  input  logic                 S_VLD,
  output logic                 S_RDY,
  output logic [WIDTH-1:0]     Z,
  output logic                 Z_VLD,
  output logic                 ERR
);

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_n_q;
  logic [WIDTH-1:0] z_q;
  logic             zvld_q;
  logic             rdy_q;
  logic             err_q;

  logic             accept;
  logic             s_oor;
  logic             start_switch;
  logic             cnt_zero;
  logic [WIDTH-1:0] z_cur;
  logic [WIDTH-1:0] z_new;

  // rdy_q is only ever high in STEADY, so it doubles as the accept qualifier.
  assign accept       = S_VLD && rdy_q;
  assign s_oor        = (32'(S) >= NCH);
  assign start_switch = accept && !s_oor && (S != sel_q);

  assign z_cur = I[32'(sel_q) * WIDTH +: WIDTH];
  assign z_new = I[32'(sel_n_q) * WIDTH +: WIDTH];

  gf180mcu_fd_sc_mcu9t5v0__muxn_hcnt u_hcnt (
    .CLK   (CLK),
    .RN    (RN),
    .load  (start_switch),
    .value (CNT_W'(BREAK_CYC - 1)),
    .dec   (state_q == BREAK),
    .zero  (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= STEADY;
      sel_q   <= SEL_W'(RST_SEL);
      sel_n_q <= SEL_W'(RST_SEL);
      z_q     <= '0;
      zvld_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        STEADY: begin
          z_q    <= z_cur;
          zvld_q <= 1'b1;
          rdy_q  <= 1'b1;
          if (accept && s_oor) begin
            err_q <= 1'b1;
          end else if (start_switch) begin
            state_q <= BREAK;
            sel_n_q <= S;
            zvld_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__MUXN_PARK_EN
            z_q     <= '0;
`endif
          end
        end
        BREAK: begin
          zvld_q <= 1'b0;
          rdy_q  <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__MUXN_PARK_EN
          z_q    <= '0;
`endif
          if (cnt_zero) begin
            state_q <= MAKE;
          end
        end
        MAKE: begin
          sel_q   <= sel_n_q;
          z_q     <= z_new;
          zvld_q  <= 1'b1;
          rdy_q   <= 1'b1;
          state_q <= STEADY;
        end
        default: begin
          state_q <= STEADY;
          zvld_q  <= 1'b0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Z     = z_q;
  assign Z_VLD = zvld_q;
  assign S_RDY = rdy_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// Directed bench: 4-channel/1-cycle-break instance A, 3-channel/3-cycle-break instance B.
module tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync;

  logic        clk = 1'b0;
  logic        rn  = 1'b0;

  logic [31:0] ia  = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [1:0]  sa  = 2'd0;
  logic        sva = 1'b0;
  logic        rdya, zvlda, erra;
  logic [7:0]  za;

  logic [23:0] ib  = {8'h33, 8'h22, 8'h11};
  logic [1:0]  sb  = 2'd0;
  logic        svb = 1'b0;
  logic        rdyb, zvldb, errb;
  logic [7:0]  zb;

  int checks = 0;
  int errors = 0;

`ifdef GF180MCU_FD_SC_MCU9T5V0__MUXN_PARK_EN
  localparam logic [7:0] BREAK_Z_B = 8'h00;
`else
  localparam logic [7:0] BREAK_Z_B = 8'h11;
`endif

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(4), .BREAK_CYC(1), .RST_SEL(0)) dut_a (
    .CLK(clk), .RN(rn), .I(ia), .S(sa), .S_VLD(sva),
    .S_RDY(rdya), .Z(za), .Z_VLD(zvlda), .ERR(erra)
  );

  gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(3), .BREAK_CYC(3), .RST_SEL(0)) dut_b (
    .CLK(clk), .RN(rn), .I(ib), .S(sb), .S_VLD(svb),
    .S_RDY(rdyb), .Z(zb), .Z_VLD(zvldb), .ERR(errb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held
    tick();
    tick();
    chk("rst_a_z", 64'(za), 64'h0);
    chk("rst_a_zvld", 64'(zvlda), 64'h0);
    chk("rst_a_rdy", 64'(rdya), 64'h0);
    chk("rst_a_err", 64'(erra), 64'h0);
    chk("rst_b_rdy", 64'(rdyb), 64'h0);

    // First edge after release loads channel RST_SEL
    rn = 1'b1;
    tick();
    chk("rel_a_z", 64'(za), 64'h11);
    chk("rel_a_zvld", 64'(zvlda), 64'h1);
    chk("rel_a_rdy", 64'(rdya), 64'h1);
    chk("rel_b_z", 64'(zb), 64'h11);
    chk("rel_b_zvld", 64'(zvldb), 64'h1);

    // B: out-of-range select 3 with NCH=3
    sb = 2'd3; svb = 1'b1;
    tick();
    svb = 1'b0;
    chk("oor_b_err", 64'(errb), 64'h1);
    chk("oor_b_z", 64'(zb), 64'h11);
    chk("oor_b_zvld", 64'(zvldb), 64'h1);
    chk("oor_b_rdy", 64'(rdyb), 64'h1);
    tick();
    chk("oor_b_err_clr", 64'(errb), 64'h0);
    chk("oor_b_zvld2", 64'(zvldb), 64'h1);

    // B: switch 0->1, three break cycles, one make cycle
    sb = 2'd1; svb = 1'b1;
    tick();
    svb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("brk_b_zvld%0d", k), 64'(zvldb), 64'h0);
      chk($sformatf("brk_b_z%0d", k), 64'(zb), 64'(BREAK_Z_B));
      chk($sformatf("brk_b_rdy%0d", k), 64'(rdyb), 64'h0);
      tick();
    end
    chk("make_b_zvld", 64'(zvldb), 64'h0);
    chk("make_b_rdy", 64'(rdyb), 64'h0);
    tick();
    chk("sw_b_z", 64'(zb), 64'h22);
    chk("sw_b_zvld", 64'(zvldb), 64'h1);
    chk("sw_b_rdy", 64'(rdyb), 64'h1);
    chk("sw_b_err", 64'(errb), 64'h0);

    // A: same-channel request causes no bubble; Z tracks I[0]
    sa = 2'd0; sva = 1'b1;
    tick();
    sva = 1'b0;
    chk("same_a_zvld", 64'(zvlda), 64'h1);
    chk("same_a_rdy", 64'(rdya), 64'h1);
    chk("same_a_err", 64'(erra), 64'h0);
    ia[7:0] = 8'h5A;
    chk("same_a_z_pre", 64'(za), 64'h11);
    tick();
    chk("same_a_z_5a", 64'(za), 64'h5A);
    chk("same_a_zvld2", 64'(zvlda), 64'h1);
    ia[7:0] = 8'h11;
    tick();

    // A: switch 0->2, Z_VLD low two cycles, new data on the third edge counting the accept edge
    sa = 2'd2; sva = 1'b1;
    tick();
    sva = 1'b0;
    chk("sw_a_zvld0", 64'(zvlda), 64'h0);
    chk("sw_a_rdy0", 64'(rdya), 64'h0);
    chk("sw_a_z0", 64'(za), 64'h11);
    tick();
    chk("sw_a_zvld1", 64'(zvlda), 64'h0);
    chk("sw_a_rdy1", 64'(rdya), 64'h0);
    tick();
    chk("sw_a_z", 64'(za), 64'h33);
    chk("sw_a_zvld", 64'(zvlda), 64'h1);
    chk("sw_a_rdy", 64'(rdya), 64'h1);
    ia[23:16] = 8'h77;
    tick();
    chk("sw_a_track", 64'(za), 64'h77);

    // A: reset in the middle of a 2->1 switch discards the pending select
    sa = 2'd1; sva = 1'b1;
    tick();
    sva = 1'b0;
    chk("mid_a_zvld", 64'(zvlda), 64'h0);
    rn = 1'b0;
    #1;
    chk("mid_rst_a_z", 64'(za), 64'h0);
    chk("mid_rst_a_zvld", 64'(zvlda), 64'h0);
    chk("mid_rst_a_rdy", 64'(rdya), 64'h0);
    chk("mid_rst_a_err", 64'(erra), 64'h0);
    tick();
    rn = 1'b1;
    tick();
    chk("post_a_z", 64'(za), 64'h11);
    chk("post_a_zvld", 64'(zvlda), 64'h1);
    chk("post_a_rdy", 64'(rdya), 64'h1);
    tick();
    tick();
    chk("post_a_z_hold", 64'(za), 64'h11);
    chk("post_a_zvld_hold", 64'(zvlda), 64'h1);
    chk("post_a_err", 64'(erra), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
